// File: rtl/cp0.sv
// ============================================================================
// Module      : cp0
// Description : MIPS-style coprocessor 0 holding SR, Cause, EPC and PrID,
//               with interrupt/exception request generation and EXL mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0 #(
    parameter logic [31:0] PRID = 32'h0000_7A01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode_in,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] c_IDX_SR    = 5'd12;
    localparam logic [4:0] c_IDX_CAUSE = 5'd13;
    localparam logic [4:0] c_IDX_EPC   = 5'd14;
    localparam logic [4:0] c_IDX_PRID  = 5'd15;

    typedef enum logic [0:0] {
        MODE_NORMAL  = 1'b0,
        MODE_HANDLER = 1'b1
    } mode_t;

    mode_t       r_mode;
    logic [5:0]  r_im;
    logic        r_ie;
    logic        r_cause_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [29:0] r_epc;      // word address; EPC is always word aligned

    logic        w_exl;
    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_int_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_exl      = (r_mode == MODE_HANDLER);
    assign w_int_pend = (|(HWInt & r_im)) & r_ie & ~w_exl;
    assign w_exc_pend = (ExcCode_in != 5'd0) & ~w_exl;
    assign w_int_req  = w_int_pend | w_exc_pend;

    assign w_sr    = {16'h0000, r_im, 8'h00, w_exl, r_ie};
    assign w_cause = {r_cause_bd, 15'h0000, r_ip, 3'b000, r_exc_code, 2'b00};

    assign IntReq = w_int_req;
    assign EPC    = {r_epc, 2'b00};

    always_comb begin
        DOut = 32'h0000_0000;
        case (A1)
            c_IDX_SR:    DOut = w_sr;
            c_IDX_CAUSE: DOut = w_cause;
            c_IDX_EPC:   DOut = {r_epc, 2'b00};
            c_IDX_PRID:  DOut = PRID;
            default:     DOut = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode     <= MODE_NORMAL;
            r_im       <= 6'd0;
            r_ie       <= 1'b0;
            r_cause_bd <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 30'd0;
        end else begin
            r_ip <= HWInt;
            if (w_int_req) begin
                // Exception entry discards any concurrent mtc0 or eret.
                r_mode     <= MODE_HANDLER;
                r_exc_code <= w_int_pend ? 5'd0 : ExcCode_in;
                r_cause_bd <= BD;
                r_epc      <= BD ? (PC[31:2] - 30'd1) : PC[31:2];
            end else begin
                if (WE && (A2 == c_IDX_SR)) begin
                    r_im   <= DIn[15:10];
                    r_ie   <= DIn[0];
                    r_mode <= DIn[1] ? MODE_HANDLER : MODE_NORMAL;
                end
                if (WE && (A2 == c_IDX_EPC)) begin
                    r_epc <= DIn[31:2];
                end
                if (EXLClr) begin
                    r_mode <= MODE_NORMAL;
                end
            end
        end
    end

endmodule

`default_nettype wire
